ir_flag_unit: RTL

- Decode-side stage directly upstream of the control FSM.
- Captures the fetched instruction byte into the instruction register (IR) and presents decoded fields to the FSM and datapath.
- Maintains the N/Z condition flags from ALU results, which the FSM uses for branch decisions.
- Keeps a fetch/retire counter and a sticky halted status for the debug display.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/flag_reg.sv | 25 ++
 rtl/ir_flag_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, field positions, widths.
// Used by ir_flag_unit and its flag register.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [3:0] {
    LOAD  = 4'd0,
    STOP  = 4'd1,
    STORE = 4'd2,
    ADD   = 4'd4,
    BZ    = 4'd5,
    SUB   = 4'd6,
    NAND  = 4'd8,
    BNZ   = 4'd9,
    NOP   = 4'd10,
    BPZ   = 4'd13
  } opcode_e;

  localparam logic [2:0] SHIFT = 3'b011;
  localparam logic [2:0] ORI   = 3'b111;

  localparam int OP_MSB    = 3;
  localparam int OP_LSB    = 0;
  localparam int R1_MSB    = 7;
  localparam int R1_LSB    = 6;
  localparam int R2_MSB    = 5;
  localparam int R2_LSB    = 4;
  localparam int IMM4_MSB  = 7;
  localparam int IMM4_LSB  = 4;
  localparam int IMM5_MSB  = 7;
  localparam int IMM5_LSB  = 3;
  localparam int SHAMT_MSB = 4;
  localparam int SHAMT_LSB = 3;
  localparam int SHDIR_BIT = 5;

  // Only nibbles 12 and 14 fall outside the opcode map.
  function automatic logic op_illegal(
    input logic [3:0] op
  );
    return (op == 4'd12) || (op == 4'd14);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// N/Z condition flags computed from the ALU result.
// Written on we unless frozen by halt.
module flag_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              freeze,
  input  logic [DATA_W-1:0] din,
  output logic              N,
  output logic              Z
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      N <= 1'b0;
      Z <= 1'b0;
    end else if (we && !freeze) begin
      Z <= (din == '0);
      N <= din[DATA_W-1];
    end
  end

endmodule

// File: rtl/ir_flag_unit.sv
// Instruction register, field decode, N/Z flags and fetch status.
// Define ILLEGAL_OP_EN to build sticky illegal-opcode detection.
module ir_flag_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              IRload,
  input  logic              FlagWrite,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              Stop,
  output logic [3:0]        instr,
  output logic              N,
  output logic              Z,
  output logic [1:0]        r1_idx,
  output logic [1:0]        r2_idx,
  output logic [DATA_W-1:0] imm4_sx,
  output logic [DATA_W-1:0] imm5_zx,
  output logic [1:0]        shamt,
  output logic              shdir,
  output logic              ir_valid,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              halted,
  output logic              illegal
);

  logic [DATA_W-1:0] ir;
  logic              freeze;
  logic              cap;

  // The Stop edge itself is already blocked.
  assign freeze = halted | Stop;
  assign cap    = IRload & ~freeze;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      if (cap) begin
        ir        <= mem_rdata;
        ir_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (Stop) begin
        halted <= 1'b1;
      end
    end
  end

  flag_reg #(
    .DATA_W (DATA_W)
  ) u_flag_reg (
    .clock  (clock),
    .reset  (reset),
    .we     (FlagWrite),
    .freeze (freeze),
    .din    (alu_result),
    .N      (N),
    .Z      (Z)
  );

  assign instr   = ir[OP_MSB:OP_LSB];
  assign r1_idx  = ir[R1_MSB:R1_LSB];
  assign r2_idx  = ir[R2_MSB:R2_LSB];
  assign shamt   = ir[SHAMT_MSB:SHAMT_LSB];
  assign shdir   = ir[SHDIR_BIT];
  assign imm4_sx = {{(DATA_W-4){ir[IMM4_MSB]}},
                    ir[IMM4_MSB:IMM4_LSB]};
  assign imm5_zx = {{(DATA_W-5){1'b0}},
                    ir[IMM5_MSB:IMM5_LSB]};

`ifdef ILLEGAL_OP_EN
  logic ill_q;

  // IR only changes on capture, so checking it once valid
  // flags the edge after an illegal fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ill_q <= 1'b0;
    end else if (ir_valid && !freeze &&
                 op_illegal(ir[OP_MSB:OP_LSB])) begin
      ill_q <= 1'b1;
    end
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
